seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display that shares a single BCD-to-7-segment decoder across all digits. It holds a double-buffered BCD word, steps through the digits at a programmable slot rate and drives the shared decoder's 4-bit input. It also drives a one-hot digit enable, inserts an anti-ghosting blank gap between digits and optionally suppresses leading zeros. It sits between the value producer (counter, ALU result) and the decoder/pin drivers.

---
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, one shared
// decoder input, one-hot digit enables, blank gap per slot, leading-zero blanking.

// Per-digit zero-chain stage: "this digit and every digit above it are zero".
module seg7_lz_lane (
  input  logic [3:0] digit,
  input  logic       zero_above,
  output logic       zero_here
);
  assign zero_here = zero_above & (digit == 4'h0);
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         frame_end;
  logic                         pending_q;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q, active_q;
  logic [NUM_DIGITS-1:0]        en_d;
  logic [3:0]                   bcd_d;

  // zero_chain[g] = active digits g..top are all zero; digit 0 never blanks
  logic [NUM_DIGITS:1]          zero_chain;
  logic [NUM_DIGITS-1:0]        lz_blank;

  assign zero_chain[NUM_DIGITS] = 1'b1;
  assign lz_blank[0]            = 1'b0;

  generate
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lane
      seg7_lz_lane u_lane (
        .digit      (active_q[g]),
        .zero_above (zero_chain[g+1]),
        .zero_here  (zero_chain[g])
      );
      assign lz_blank[g] = lz_suppress & zero_chain[g];
    end
  endgenerate

  assign load_ready = ~pending_q;

  // Slot timing: counter runs 0..PRESCALE-1 across BLANK then SHOW of one digit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_BLANK: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == CNT_LAST && idx_q == IDX_LAST) begin
          // frame boundary wins over a coincident enable drop
          frame_end = 1'b1;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = enable ? S_BLANK : S_IDLE;
        end else if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
          state_d = S_BLANK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state; active only changes on entry to
  // BLANK or IDLE, so reading it here never mixes two words inside a SHOW.
  always_comb begin
    en_d  = '0;
    bcd_d = 4'hF;
    if (state_d == S_SHOW) begin
      en_d[idx_d] = 1'b1;
      bcd_d       = lz_blank[idx_d] ? 4'hF : active_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
      digit_en   <= '0;
      bcd_out    <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      digit_en   <= en_d;
      bcd_out    <= bcd_d;
      frame_done <= frame_end;
      // copy and load are exclusive: a load needs pending=0, a copy needs pending=1
      if (pending_q && (state_q == S_IDLE || frame_end)) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end else if (load_valid && !pending_q) begin
        shadow_q  <= load_data;
        pending_q <= 1'b1;
      end
    end
  end

endmodule
